// File: rtl/fifo_row_packer_pkg.sv
// fifo_row_packer_pkg
// Shared types and helpers for the FIFO row packer.
//   buf_state_t  : FILL (popping allowed) / HOLD (hold slot occupied, popping stopped)
//   stream_ctl_t : control half of the row stream handshake (valid, last); the
//                  data half is sized by the instantiating module.
//   cnt_w(n)     : counter width for a 0..n-1 counter, never less than one bit.
package fifo_row_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } buf_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } stream_ctl_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_row_packer_row_buffer_2.sv
// row_buffer_2
// Two-entry row buffer (output register plus one hold register) with
// valid/ready on both sides. The output register is what downstream sees; the
// hold register catches a row completed while the output is stalled.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   clear_i            : synchronous clear, drops both entries
//   in_valid_i/ready_o : completed row from the packer (ready depends on state only)
//   in_data_i/last_i   : incoming row and its last-row flag
//   out_valid_o/ready_i: downstream handshake
//   out_data_o/last_o  : registered row and last-row flag
module row_buffer_2
  import fifo_row_packer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o
);

  buf_state_t       state_reg, state_next;
  stream_ctl_t      out_ctl_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] hold_data_reg;
  logic             hold_last_reg;

  logic out_free;
  logic load_in_out;
  logic load_in_hold;
  logic move_hold;

  // Output slot can accept a row this edge if empty or being consumed now.
  assign out_free     = ~out_ctl_reg.valid | out_ready_i;
  assign load_in_out  = in_valid_i & (state_reg == ST_FILL) &  out_free;
  assign load_in_hold = in_valid_i & (state_reg == ST_FILL) & ~out_free;
  assign move_hold    = (state_reg == ST_HOLD) & out_free;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_FILL;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = ST_FILL;
    end else begin
      case (state_reg)
        ST_FILL: if (load_in_hold) state_next = ST_HOLD;
        ST_HOLD: if (out_free)     state_next = ST_FILL;
        default:                   state_next = ST_FILL;
      endcase
    end
  end

  // Output logic: ready is a function of state alone, so no ready-to-ready path.
  always_comb begin
    in_ready_o  = (state_reg == ST_FILL);
    out_valid_o = out_ctl_reg.valid;
    out_last_o  = out_ctl_reg.last;
    out_data_o  = out_data_reg;
  end

  // Output register; the held row always has priority since it is older.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_ctl_reg  <= '0;
      out_data_reg <= '0;
    end else if (clear_i) begin
      out_ctl_reg.valid <= 1'b0;
    end else if (move_hold) begin
      out_ctl_reg  <= '{valid: 1'b1, last: hold_last_reg};
      out_data_reg <= hold_data_reg;
    end else if (load_in_out) begin
      out_ctl_reg  <= '{valid: 1'b1, last: in_last_i};
      out_data_reg <= in_data_i;
    end else if (out_ctl_reg.valid & out_ready_i) begin
      out_ctl_reg.valid <= 1'b0;
    end
  end

  // Hold register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
    end else if (load_in_hold & ~clear_i) begin
      hold_data_reg <= in_data_i;
      hold_last_reg <= in_last_i;
    end
  end

endmodule

// File: rtl/fifo_row_packer.sv
// fifo_row_packer
// Pops scalar elements from the CDC FIFO read side and packs ROW_LEN of them
// into a row vector, presented on a valid/ready stream with a last-row flag
// marking row ROWS-1 of each matrix.
// Ports:
//   clk, reset_n     : FIFO read-domain clock, asynchronous active-low reset
//   clear_i          : synchronous clear of partial row, buffered rows and row index
//   fifo_empty_i     : FIFO empty flag
//   fifo_data_i      : FIFO read data
//   fifo_incr_o      : pop request (combinational, independent of row_ready_i)
//   row_valid_o/ready_i : output row handshake
//   row_data_o       : packed row, element 0 (first popped) in the low bits
//   row_last_o       : row is the last of its matrix
module fifo_row_packer
  import fifo_row_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 4,
  parameter int ROWS       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear_i,
  input  logic                          fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]         fifo_data_i,
  output logic                          fifo_incr_o,
  output logic                          row_valid_o,
  input  logic                          row_ready_i,
  output logic [ROW_LEN*DATA_WIDTH-1:0] row_data_o,
  output logic                          row_last_o
);

  localparam int EW = cnt_w(ROW_LEN);
  localparam int RW = cnt_w(ROWS);
  localparam logic [EW-1:0] ELEM_LAST = EW'(ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  logic [EW-1:0] elem_cnt_reg, elem_cnt_next;
  logic [RW-1:0] row_cnt_reg, row_cnt_next;

  // Only the first ROW_LEN-1 elements need storage; the final one is taken
  // straight from the FIFO on the completing pop.
  logic [DATA_WIDTH-1:0]         asm_reg [ROW_LEN-1];
  logic [ROW_LEN-2:0]            slot_we;
  logic [ROW_LEN*DATA_WIDTH-1:0] row_word;

  logic pop;
  logic row_done;
  logic buf_in_ready;

  assign pop         = reset_n & ~clear_i & ~fifo_empty_i & buf_in_ready;
  assign fifo_incr_o = pop;
  assign row_done    = pop & (elem_cnt_reg == ELEM_LAST);

  for (genvar gi = 0; gi < ROW_LEN - 1; gi++) begin : g_slot
    assign slot_we[gi] = pop & (elem_cnt_reg == EW'(gi));
    assign row_word[gi*DATA_WIDTH +: DATA_WIDTH] = asm_reg[gi];
  end
  assign row_word[(ROW_LEN-1)*DATA_WIDTH +: DATA_WIDTH] = fifo_data_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ROW_LEN - 1; k++) asm_reg[k] <= '0;
    end else begin
      for (int k = 0; k < ROW_LEN - 1; k++) begin
        if (slot_we[k]) asm_reg[k] <= fifo_data_i;
      end
    end
  end

  // Rows leave in completion order, so tagging the index at completion gives
  // the same sequence as tagging at output-register entry.
  always_comb begin
    elem_cnt_next = elem_cnt_reg;
    row_cnt_next  = row_cnt_reg;
    if (clear_i) begin
      elem_cnt_next = '0;
      row_cnt_next  = '0;
    end else begin
      if (pop)
        elem_cnt_next = (elem_cnt_reg == ELEM_LAST) ? '0 : elem_cnt_reg + EW'(1);
      if (row_done)
        row_cnt_next = (row_cnt_reg == ROW_LAST) ? '0 : row_cnt_reg + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elem_cnt_reg <= '0;
      row_cnt_reg  <= '0;
    end else begin
      elem_cnt_reg <= elem_cnt_next;
      row_cnt_reg  <= row_cnt_next;
    end
  end

  row_buffer_2 #(
    .WIDTH (ROW_LEN*DATA_WIDTH)
  ) u_row_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_i),
    .in_valid_i  (row_done),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (row_word),
    .in_last_i   (row_cnt_reg == ROW_LAST),
    .out_valid_o (row_valid_o),
    .out_ready_i (row_ready_i),
    .out_data_o  (row_data_o),
    .out_last_o  (row_last_o)
  );

endmodule

// File: tb/tb_fifo_row_packer.sv
// tb_fifo_row_packer
// Randomised FIFO/downstream stimulus against a queue-based reference model.
// The driver owns the FIFO model and pushes each completed row into a
// scoreboard; a separate monitor compares whatever the DUT presents.
module tb_fifo_row_packer;

  localparam int DW  = 8;
  localparam int RL  = 4;
  localparam int NR  = 2;
  localparam int RWD = DW * RL;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear_i = 1'b0;
  logic           fifo_empty_i = 1'b1;
  logic [DW-1:0]  fifo_data_i = '0;
  logic           fifo_incr_o;
  logic           row_valid_o;
  logic           row_ready_i = 1'b0;
  logic [RWD-1:0] row_data_o;
  logic           row_last_o;

  always #5 clk = ~clk;

  fifo_row_packer #(
    .DATA_WIDTH (DW),
    .ROW_LEN    (RL),
    .ROWS       (NR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_incr_o  (fifo_incr_o),
    .row_valid_o  (row_valid_o),
    .row_ready_i  (row_ready_i),
    .row_data_o   (row_data_o),
    .row_last_o   (row_last_o)
  );

  typedef struct {
    logic [RWD-1:0] data;
    logic           last;
    int             cyc;
  } exp_row_t;

  exp_row_t      sb[$];
  logic [DW-1:0] partial[$];
  int            row_idx = 0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_rows = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] head;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_flush();
    sb.delete();
    partial.delete();
    row_idx = 0;
  endtask

  // One clock cycle of stimulus plus the reference model's view of it.
  task automatic drive(input bit gap, input bit rdy, input bit clr);
    logic [RWD-1:0] r;
    bit             exp_incr;
    @(negedge clk);
    cyc++;
    fifo_empty_i = gap;
    fifo_data_i  = head;
    clear_i      = clr;
    row_ready_i  = clr ? 1'b0 : rdy;
    #1;
    // Popping is allowed whenever data is there, no clear, and fewer than two
    // complete rows are waiting downstream.
    exp_incr = !gap && !clr && (sb.size() < 2);
    chk("fifo_incr", 64'(fifo_incr_o), 64'(exp_incr));
    if (clr) begin
      model_flush();
    end else if (exp_incr) begin
      partial.push_back(head);
      head = DW'($urandom);
      if (partial.size() == RL) begin
        r = '0;
        foreach (partial[k]) r[k*DW +: DW] = partial[k];
        sb.push_back('{data: r, last: (row_idx == NR - 1), cyc: cyc});
        row_idx = (row_idx + 1) % NR;
        partial.delete();
      end
    end
  endtask

  task automatic async_reset();
    mon_en = 1'b0;
    @(negedge clk);
    fifo_empty_i = 1'b0;
    row_ready_i  = 1'b0;
    clear_i      = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_incr",  64'(fifo_incr_o), 64'(0));
    chk("rst_valid", 64'(row_valid_o), 64'(0));
    chk("rst_data",  64'(row_data_o),  64'(0));
    chk("rst_last",  64'(row_last_o),  64'(0));
    repeat (3) begin
      @(negedge clk);
      #1 chk("incr_in_reset", 64'(fifo_incr_o), 64'(0));
    end
    fifo_empty_i = 1'b1;
    reset_n      = 1'b1;
    model_flush();
    mon_en = 1'b1;
  endtask

  // Monitor: compares the presented row against the scoreboard head.
  initial begin : monitor
    bit exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && reset_n && !clear_i) begin
        exp_v = (sb.size() > 0) && (sb[0].cyc < cyc);
        chk("row_valid", 64'(row_valid_o), 64'(exp_v));
        if (row_valid_o && exp_v) begin
          chk("row_data", 64'(row_data_o), 64'(sb[0].data));
          chk("row_last", 64'(row_last_o), 64'(sb[0].last));
          if (row_ready_i) begin
            n_rows++;
            $display("row %0d: data=%h last=%0b", n_rows, row_data_o, row_last_o);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    head = DW'($urandom);
    #12;
    chk("init_incr",  64'(fifo_incr_o), 64'(0));
    chk("init_valid", 64'(row_valid_o), 64'(0));
    chk("init_data",  64'(row_data_o),  64'(0));
    chk("init_last",  64'(row_last_o),  64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Full-rate streaming, then a long stall, then release.
    repeat (40) drive(1'b0, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 1'b0);
    // Two elements, a long empty gap, then the rest of the row.
    repeat (2)  drive(1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b1, 1'b1, 1'b0);
    repeat (6)  drive(1'b0, 1'b1, 1'b0);

    repeat (1500)
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);

    // Reset landing mid-row.
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    async_reset();

    repeat (1500)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0);

    repeat (10) drive(1'b1, 1'b1, 1'b0);
    chk("drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_row_packer.md
# fifo_row_packer

Read-side consumer of the clock-domain-crossing FIFO that feeds the matrix multiplier. It pops scalar elements from the FIFO's read interface and packs ROW_LEN consecutive elements into one row vector. It presents each row on a valid/ready stream to the multiplier's operand loader, flagging the last row of each ROWS-row matrix. It runs entirely in the FIFO read clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, element width; must match the FIFO's DATA_WIDTH.
- ROW_LEN, 4, elements per row; must be ≥ 2 (not required to be a power of two).
- ROWS, 4, rows per matrix; must be ≥ 1; drives row_last_o.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  FIFO read-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear: drops any partial row, the held row and the output row, and zeroes the row index.
- fifo_empty_i  in  1  FIFO read-side empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO read data; valid while fifo_empty_i=0.
- fifo_incr_o  out  1  pop request to the FIFO read increment.
- row_valid_o  out  1  output row valid.
- row_ready_i  in  1  downstream ready.
- row_data_o  out  ROW_LEN*DATA_WIDTH  packed row; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; element 0 is the first one popped.
- row_last_o  out  1  qualifies row_data_o; 1 when this row is row ROWS-1 of the current matrix.

## Operation
- Pop rule (combinational): fifo_incr_o = reset_n & ~clear_i & ~fifo_empty_i & ~hold_full.
  - A pop happens in every cycle fifo_incr_o=1; fifo_data_i is captured on that edge.
- Element counter elem_cnt has width max(1, $clog2(ROW_LEN)) and runs 0..ROW_LEN-1.
  - Each pop writes fifo_data_i into slot elem_cnt of the assembly register.
  - It then increments, wrapping to 0 after ROW_LEN-1.
- Row completion, meaning a pop with elem_cnt==ROW_LEN-1:
  - If the output slot is free, or is being consumed this cycle (row_valid_o & row_ready_i), the completed row (assembly slots plus the incoming element) loads directly into the output register.
  - Otherwise it loads into the hold register and hold_full is set.
- State machine:
  - FILL (hold_full=0): popping allowed.
  - HOLD (hold_full=1): popping stopped. Moves to FILL on the edge where the held row transfers to the output register (output slot free or consumed).
- Output register: row_valid_o is set on load and cleared on consumption when no new row loads in the same cycle.
  - row_data_o and row_last_o stay stable while row_valid_o=1 and row_ready_i=0.
- Row index row_cnt (width max(1, $clog2(ROWS))) is attached to each row when it enters the output register.
  - It increments on each load and wraps to 0 after ROWS-1.
  - row_last_o = (attached index == ROWS-1).
- clear_i:
  - Zeroes elem_cnt and row_cnt and clears hold_full and row_valid_o.
  - Inhibits popping in the same cycle.
  - Takes priority over every simultaneous event.
- Boundary conditions:
  - FIFO empty mid-row: the partial row is kept indefinitely and resumes on the next pop.
  - Downstream stalled: at most two complete rows are buffered (output and hold); then popping stops.
  - Reset mid-row: all contents are lost and no pop is issued while reset_n=0.

## Timing
- Reset values: fifo_incr_o=0, row_valid_o=0, row_data_o=0, row_last_o=0; internally elem_cnt=0, row_cnt=0, hold_full=0.
- Latency: the last element of a row popped at edge t gives row_valid_o=1 after edge t (visible in cycle t+1), provided the output slot is free.
- Throughput: one row per ROW_LEN cycles with FIFO non-empty and row_ready_i=1; no bubble between rows.
- HOLD to output transfer: the edge with row_valid_o & row_ready_i moves the held row out. Popping resumes in the next cycle.
- All outputs except fifo_incr_o are registered. fifo_incr_o is combinational from fifo_empty_i, clear_i, reset_n and registered state only; no path from row_ready_i.

## Structure
- The shared package holds the stream handshake type (valid, last, data parameterised by width) and the helper function cnt_w(n) = max(1, $clog2(n)).
- Sub-module row_buffer_2: a two-entry (output plus hold) row buffer with valid/ready and last, isolating the skid logic from the packing counters.

## Test plan
- Basic pack, DATA_WIDTH=8, ROW_LEN=4, ROWS=2: push 0x01..0x08, row_ready_i=1 → row 0x04030201 with last=0, then 0x08070605 with last=1; each row valid one cycle after its 4th pop.
- Backpressure: push 12 elements with row_ready_i=0 → exactly 8 pops, then fifo_incr_o=0 and row 0x04030201 held stable. Release ready → rows come out in order and the remaining 4 pops resume the cycle after the first consume.
- Empty mid-row: push 0xA1, 0xA2, gap of 10 cycles, then 0xA3, 0xA4 → single row 0xA4A3A2A1 and no spurious valid during the gap.
- Simultaneous consume and complete: output valid with ready=1 in the same cycle as a 4th pop → new row loads directly, row_valid_o stays 1 and hold_full stays 0.
- clear_i with 2 elements packed and one row pending → next cycle row_valid_o=0 and no pop that cycle. The next 4 pushes form a fresh row with last=0 (row index restarted).
- Async reset asserted mid-row between clock edges → outputs go to reset values immediately and fifo_incr_o=0 throughout reset.
